mem_port_arbiter: RTL and testbench

//  Shares the single main-memory line port between the I-cache and D-cache CMUs.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Line-transfer port bundles: one cache-CMU request port and the main-memory line port.
// The CMU side holds req and its fields until ack. Memory completes each strobe with one ack pulse.

interface cmu_port_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              ack;
    logic [LINE_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

interface mem_line_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              ack;

    modport master (output stb, we, addr, wdata, input  rdata, ack);
    modport slave  (input  stb, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory line port between the I-CMU and D-CMU, one transfer at a time, with a watchdog.
// Latency: request->mem_stb 1 cycle; mem_ack->x_ack 1 cycle; all outputs registered.
// Backpressure: requesters hold req until ack; mem_busy stays high from the grant through the ack cycle.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    cmu_port_if.slave  i_port,
    cmu_port_if.slave  d_port,
    mem_line_if.master mem,
    output logic       err,
    output logic       mem_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;       // 0: I served last, 1: D served last
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              grant_i, grant_d;
    logic              finish;
    logic [LINE_W-1:0] rdata_n;

    // When both sides ask, the side not served last wins, so neither waits more than one transfer.
    assign grant_d = d_port.req && (!i_port.req || !last_q);
    assign grant_i = i_port.req && (!d_port.req ||  last_q);
    assign finish  = mem.ack || (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        stb_d     = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = 1'b0;
        rdata_n   = mem.ack ? mem.rdata : '0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GRANT_D;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    we_d    = d_port.we;
                    addr_d  = d_port.addr & LINE_MASK;
                    wdata_d = d_port.wdata;
                end else if (grant_i) begin
                    state_d = GRANT_I;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    we_d    = i_port.we;
                    addr_d  = i_port.addr & LINE_MASK;
                    wdata_d = i_port.wdata;
                end
            end
            GRANT_I, GRANT_D: begin
                stb_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the last watchdog cycle still counts as a normal completion.
                if (finish) begin
                    state_d = DONE;
                    stb_d   = 1'b0;
                    err_d   = !mem.ack;
                    if (state_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rdata_n;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rdata_n;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign mem.stb      = stb_q;
    assign mem.we       = we_q;
    assign mem.addr     = addr_q;
    assign mem.wdata    = wdata_q;
    assign i_port.ack   = i_ack_q;
    assign i_port.rdata = i_rdata_q;
    assign d_port.ack   = d_ack_q;
    assign d_port.rdata = d_rdata_q;
    assign err          = err_q;
    assign mem_busy     = busy_q;

`ifndef SYNTHESIS
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rstn)
        !(i_port.ack && d_port.ack));
    a_stb_in_grant: assert property (@(posedge clk) disable iff (!rstn)
        mem.stb |-> (state_q == GRANT_I || state_q == GRANT_D));
    a_err_with_ack: assert property (@(posedge clk) disable iff (!rstn)
        err |-> (i_port.ack || d_port.ack));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester and memory models feed a scoreboard,
// an independent monitor pops expectations whenever an ack appears.

module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 8;
    localparam int NEVER   = 1000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic err, mem_busy;

    always #5 clk = ~clk;

    cmu_port_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_if ();
    cmu_port_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_if ();
    mem_line_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mem_if ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_port   (i_if),
        .d_port   (d_if),
        .mem      (mem_if),
        .err      (err),
        .mem_busy (mem_busy)
    );

    typedef struct {
        bit                side;   // 0: I, 1: D
        logic [LINE_W-1:0] rdata;
        bit                err;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   err_seen = 0;

    // Knobs shared between the sequencer and the requester / memory models
    int                i_todo = 0, d_todo = 0, gap_max = 0;
    bit                i_act = 0, d_act = 0;
    bit                i_fix = 0, d_fix = 0;
    logic              fix_we = 1'b0;
    logic [ADDR_W-1:0] fix_addr = '0;
    logic [LINE_W-1:0] fix_wdata = '0;
    int                force_delay = -1;
    bit                junk_ack = 0;
    bit                last_srv = 0;
    logic [ADDR_W-1:0] last_grant_addr = '0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // I-side requester
    initial begin : req_i
        int n;
        i_if.req = 1'b0; i_if.we = 1'b0; i_if.addr = '0; i_if.wdata = '0;
        forever begin
            @(negedge clk);
            if (i_todo > 0 && rstn) begin
                i_todo--;
                i_act = 1;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                i_if.we    = i_fix ? fix_we    : 1'($urandom_range(1, 0));
                i_if.addr  = i_fix ? fix_addr  : $urandom;
                i_if.wdata = i_fix ? fix_wdata : rand_line();
                i_if.req   = 1'b1;
                for (n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    if (!rstn || i_if.ack) break;
                end
                if (rstn && !i_if.ack) check("i_ack_timeout", 128'(1), 128'(0));
                i_if.req = 1'b0;
                i_act = 0;
            end
        end
    end

    // D-side requester
    initial begin : req_d
        int n;
        d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = '0; d_if.wdata = '0;
        forever begin
            @(negedge clk);
            if (d_todo > 0 && rstn) begin
                d_todo--;
                d_act = 1;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                d_if.we    = d_fix ? fix_we    : 1'($urandom_range(1, 0));
                d_if.addr  = d_fix ? fix_addr  : $urandom;
                d_if.wdata = d_fix ? fix_wdata : rand_line();
                d_if.req   = 1'b1;
                for (n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    if (!rstn || d_if.ack) break;
                end
                if (rstn && !d_if.ack) check("d_ack_timeout", 128'(1), 128'(0));
                d_if.req = 1'b0;
                d_act = 0;
            end
        end
    end

    // Memory model plus arbitration reference: predicts the owner of each new strobe
    initial begin : memory
        bit                in_flight;
        int                idx, delay, stb_len, r;
        bit                side;
        logic              s_we;
        logic [ADDR_W-1:0] s_addr;
        logic [LINE_W-1:0] s_wdata, rd;
        exp_t              e;
        in_flight = 0; idx = 0; delay = 0; stb_len = 0;
        mem_if.ack = 1'b0; mem_if.rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                mem_if.ack = 1'b0;
                in_flight  = 0;
                last_srv   = 0;
                exp_q.delete();
                continue;
            end
            if (mem_if.stb) begin
                if (!in_flight) begin
                    in_flight = 1; idx = 0; stb_len = 0;
                    if (!i_if.req && !d_if.req) check("spurious_grant", 128'(1), 128'(0));
                    side     = (i_if.req && d_if.req) ? !last_srv : d_if.req;
                    last_srv = side;
                    grant_log.push_back(int'(side));
                    s_we    = side ? d_if.we    : i_if.we;
                    s_addr  = (side ? d_if.addr : i_if.addr) & ~32'hF;
                    s_wdata = side ? d_if.wdata : i_if.wdata;
                    last_grant_addr = mem_if.addr;
                    check("grant_we",    128'(mem_if.we),    128'(s_we));
                    check("grant_addr",  128'(mem_if.addr),  128'(s_addr));
                    check("grant_wdata", mem_if.wdata,       s_wdata);
                    if (force_delay >= 0) delay = force_delay;
                    else begin
                        r = $urandom_range(19, 0);
                        delay = (r == 0) ? TIMEOUT - 1 : (r == 1) ? NEVER : $urandom_range(6, 0);
                    end
                    rd      = rand_line();
                    e.side  = side;
                    e.rdata = (delay < TIMEOUT) ? rd : '0;
                    e.err   = (delay >= TIMEOUT);
                    exp_q.push_back(e);
                end else begin
                    idx++;
                    check("stb_hold", 128'(mem_if.we === s_we && mem_if.addr === s_addr &&
                                           mem_if.wdata === s_wdata), 128'(1));
                end
                stb_len++;
                mem_if.ack   = (idx == delay);
                mem_if.rdata = (idx == delay) ? rd : rand_line();
            end else begin
                if (in_flight) begin
                    in_flight = 0;
                    check("stb_len", 128'(stb_len), 128'((delay < TIMEOUT) ? delay + 1 : TIMEOUT));
                end
                mem_if.ack   = junk_ack && ($urandom_range(5, 0) == 0);
                mem_if.rdata = rand_line();
            end
        end
    end

    // Monitor: pops one expectation per ack
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) continue;
            if (i_if.ack && d_if.ack) check("ack_overlap", 128'(1), 128'(0));
            if (err && !(i_if.ack || d_if.ack)) check("err_without_ack", 128'(1), 128'(0));
            if (mem_busy !== (mem_if.stb || i_if.ack || d_if.ack))
                check("mem_busy", 128'(mem_busy), 128'(mem_if.stb || i_if.ack || d_if.ack));
            if (err) err_seen++;
            if (i_if.ack || d_if.ack) begin
                if (exp_q.size() == 0) check("unexpected_ack", 128'(1), 128'(0));
                else begin
                    e = exp_q.pop_front();
                    check("ack_side",  128'(d_if.ack), 128'(e.side));
                    check("ack_rdata", d_if.ack ? d_if.rdata : i_if.rdata, e.rdata);
                    check("ack_err",   128'(err), 128'(e.err));
                end
            end
        end
    end

    task automatic wait_idle(int budget);
        int n = 0;
        while ((i_todo > 0 || d_todo > 0 || i_act || d_act || mem_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_idle_timeout", 128'(1), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk); #2 rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : global_watchdog
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : sequencer
        int n, e0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stb",     128'(mem_if.stb),   128'(0));
        check("rst_we",      128'(mem_if.we),    128'(0));
        check("rst_addr",    128'(mem_if.addr),  128'(0));
        check("rst_wdata",   mem_if.wdata,       128'(0));
        check("rst_i_ack",   128'(i_if.ack),     128'(0));
        check("rst_d_ack",   128'(d_if.ack),     128'(0));
        check("rst_i_rdata", i_if.rdata,         128'(0));
        check("rst_d_rdata", d_if.rdata,         128'(0));
        check("rst_err",     128'(err),          128'(0));
        check("rst_busy",    128'(mem_busy),     128'(0));
        @(posedge clk); #2 rstn = 1'b1;

        // Single I refill at 0x1000, ack on the 4th strobe cycle
        i_fix = 1; fix_we = 1'b0; fix_addr = 32'h1000; fix_wdata = '0;
        force_delay = 3; i_todo = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (i_if.req) break;
        end
        check("i_req_seen", 128'(i_if.req), 128'(1));
        check("stb_before_grant", 128'(mem_if.stb), 128'(0));
        @(posedge clk); #1;
        check("req_to_stb_latency", 128'(mem_if.stb), 128'(1));
        check("t1_mem_addr", 128'(mem_if.addr), 128'(32'h1000));
        check("t1_busy", 128'(mem_busy), 128'(1));
        wait_idle(200);
        i_fix = 0;

        // Simultaneous requests after reset: D first, then I
        do_reset();
        grant_log.delete();
        force_delay = -1; gap_max = 0;
        i_todo = 1; d_todo = 1;
        wait_idle(2000);
        check("t2_grants", 128'(grant_log.size()), 128'(2));
        if (grant_log.size() == 2) begin
            check("t2_first_d",  128'(grant_log[0]), 128'(1));
            check("t2_second_i", 128'(grant_log[1]), 128'(0));
        end

        // D requests back-to-back while I waits: strict alternation
        grant_log.delete();
        force_delay = 2;
        d_todo = 4; i_todo = 2;
        wait_idle(2000);
        check("t3_grants", 128'(grant_log.size()), 128'(6));
        if (grant_log.size() == 6) begin
            check("t3_g0", 128'(grant_log[0]), 128'(1));
            check("t3_g1", 128'(grant_log[1]), 128'(0));
            check("t3_g2", 128'(grant_log[2]), 128'(1));
            check("t3_g3", 128'(grant_log[3]), 128'(0));
        end

        // D writeback at 0x2004, memory silent: watchdog fires
        d_fix = 1; fix_we = 1'b1; fix_addr = 32'h2004; fix_wdata = {16{8'hA5}};
        force_delay = NEVER; e0 = err_seen;
        d_todo = 1;
        wait_idle(1000);
        check("t4_mem_addr", 128'(last_grant_addr), 128'(32'h2000));
        check("t4_err_pulses", 128'(err_seen - e0), 128'(1));
        check("t4_d_rdata", d_if.rdata, 128'(0));
        d_fix = 0;

        // Ack on the final watchdog cycle completes normally
        force_delay = TIMEOUT - 1; e0 = err_seen;
        i_todo = 1;
        wait_idle(1000);
        check("t5_err_pulses", 128'(err_seen - e0), 128'(0));

        // Reset mid-transfer
        force_delay = 50;
        i_todo = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mem_if.stb) break;
        end
        check("t6_stb_seen", 128'(mem_if.stb), 128'(1));
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_stb_drop",  128'(mem_if.stb), 128'(0));
        check("t6_busy_drop", 128'(mem_busy),   128'(0));
        @(posedge clk); #2 rstn = 1'b1;
        wait_idle(200);
        force_delay = 2;
        i_todo = 1;
        wait_idle(200);

        // Randomized traffic with stray acks outside grants
        force_delay = -1; gap_max = 3; junk_ack = 1;
        i_todo = 30; d_todo = 30;
        wait_idle(20000);
        junk_ack = 0;
        repeat (5) @(negedge clk);
        check("scoreboard_drain", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
